// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the data-memory stage.
package mem_stage_pkg;

  // writeback source select
  localparam logic [1:0] wbALU = 2'd0;
  localparam logic [1:0] wbMEM = 2'd1;
  localparam logic [1:0] wbPC  = 2'd2;

  // load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // store funct3 codes
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} mem_state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

  // control half of the captured execute bundle
  typedef struct packed {
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       regwren;
    logic       memren;
    logic       memwren;
    logic [1:0] wbsel;
  } ctl_t;

  // Access size; any funct3 not naming a byte/half access is word-sized.
  function automatic acc_size_e acc_size(input logic [2:0] f3, input logic is_store);
    acc_size_e sz;
    sz = SZ_W;
    if (is_store) begin
      if (f3 == F3_SB)      sz = SZ_B;
      else if (f3 == F3_SH) sz = SZ_H;
    end else begin
      if (f3 == F3_LB || f3 == F3_LBU)      sz = SZ_B;
      else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_H;
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store byte enables / data replication, load lane
// extract with sign/zero extension, and misalignment detection.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misalign
);

  acc_size_e         sz;
  logic [3:0][7:0]   ld_bytes;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic              uns;

  assign sz       = acc_size(funct3, is_store);
  assign ld_bytes = ld_word;
  assign ld_b     = ld_bytes[addr_lo];
  assign ld_h     = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
  assign uns      = funct3[2];

  // Store steering and alignment check. Sub-word data is replicated across
  // the word so the byte enables alone pick the lane.
  always_comb begin
    be       = 4'b1111;
    wdata    = st_data;
    misalign = 1'b0;
    case (sz)
      SZ_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{st_data[15:0]}};
        misalign = addr_lo[0];
      end
      default: misalign = (addr_lo != 2'b00);
    endcase
  end

  // Load lane extract and extension.
  always_comb begin
    ld_data = ld_word;
    case (sz)
      SZ_B:    ld_data = {{24{ld_b[7] & ~uns}}, ld_b};
      SZ_H:    ld_data = {{16{ld_h[15] & ~uns}}, ld_h};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Data-memory access stage: captures one executed op, runs an optional
// req/gnt/rvalid data-memory transaction and presents a one-cycle writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] rs2data_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  input  logic              regwren_i,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic [1:0]        wbsel_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [AWIDTH-1:0] dmem_addr_o,
  output logic [DWIDTH-1:0] dmem_wdata_o,
  output logic [3:0]        dmem_be_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DWIDTH-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [AWIDTH-1:0] wb_pc_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_regwren_o,
  output logic [DWIDTH-1:0] wb_data_o,
  output logic              misalign_o
);

  mem_state_e        state_q, state_d;
  ctl_t              ctl_q, ctl_in;
  logic [AWIDTH-1:0] pc_q;
  logic [DWIDTH-1:0] alu_q, rs2_q, ld_q;
  logic              mis_q;

  logic              accept, in_is_mem;
  logic [1:0]        al_addr;
  logic [2:0]        al_f3;
  logic              al_store;
  logic [DWIDTH-1:0] al_st;
  logic [3:0]        al_be;
  logic [DWIDTH-1:0] al_wdata, al_ld;
  logic              al_mis;

  assign ctl_in    = '{funct3: funct3_i, rd: rd_i, regwren: regwren_i,
                       memren: memren_i, memwren: memwren_i, wbsel: wbsel_i};
  assign accept    = in_valid_i && in_ready_o;
  assign in_is_mem = memren_i | memwren_i;

  // The single aligner looks at the incoming op while idle (to decide on
  // misalignment at accept) and at the captured op otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      al_addr  = alu_res_i[1:0];
      al_f3    = funct3_i;
      al_store = memwren_i;
      al_st    = rs2data_i;
    end else begin
      al_addr  = alu_q[1:0];
      al_f3    = ctl_q.funct3;
      al_store = ctl_q.memwren;
      al_st    = rs2_q;
    end
  end

  lsu_align u_align (
    .addr_lo  (al_addr),
    .funct3   (al_f3),
    .is_store (al_store),
    .st_data  (al_st),
    .ld_word  (dmem_rdata_i),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_data  (al_ld),
    .misalign (al_mis)
  );

  // State and bundle registers; the extended load value lands on rvalid in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      rs2_q   <= '0;
      ld_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctl_q <= ctl_in;
        pc_q  <= pc_i;
        alu_q <= alu_res_i;
        rs2_q <= rs2data_i;
        mis_q <= in_is_mem & al_mis;
      end
      if (state_q == WAIT && dmem_rvalid_i) ld_q <= al_ld;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (in_is_mem && !al_mis) ? REQ : WB;
      REQ:  if (dmem_gnt_i) state_d = ctl_q.memwren ? WB : WAIT;
      WAIT: if (dmem_rvalid_i) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory request and writeback outputs, zero outside their owning state.
  always_comb begin
    in_ready_o   = (state_q == IDLE);
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    dmem_be_o    = '0;
    wb_valid_o   = 1'b0;
    wb_pc_o      = '0;
    wb_rd_o      = '0;
    wb_regwren_o = 1'b0;
    wb_data_o    = '0;
    misalign_o   = 1'b0;
    if (state_q == REQ) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = ctl_q.memwren;
      dmem_addr_o  = {alu_q[AWIDTH-1:2], 2'b00};
      dmem_wdata_o = al_wdata;
      dmem_be_o    = al_be;
    end
    if (state_q == WB) begin
      wb_valid_o   = 1'b1;
      wb_pc_o      = pc_q;
      wb_rd_o      = ctl_q.rd;
      wb_regwren_o = ctl_q.regwren && (ctl_q.rd != 5'd0) && !mis_q;
      misalign_o   = mis_q;
      case (ctl_q.wbsel)
        wbMEM:   wb_data_o = ld_q;
        wbPC:    wb_data_o = pc_q + AWIDTH'(4);
        default: wb_data_o = alu_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed and random checks of mem_stage against a behavioural model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] pc, alu_res, rs2data;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        regwren, memren, memwren;
  logic [1:0]  wbsel;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_regwren, misalign;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_ld = 32'h0;

  always #5 clk = ~clk;

  mem_stage #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pc_i(pc), .alu_res_i(alu_res), .rs2data_i(rs2data), .funct3_i(funct3),
    .rd_i(rd), .regwren_i(regwren), .memren_i(memren), .memwren_i(memwren),
    .wbsel_i(wbsel),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_wdata_o(dmem_wdata), .dmem_be_o(dmem_be),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .wb_valid_o(wb_valid), .wb_pc_o(wb_pc), .wb_rd_o(wb_rd),
    .wb_regwren_o(wb_regwren), .wb_data_o(wb_data), .misalign_o(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One op through the stage: drive, play the memory side, check everything.
  task automatic run_op(input logic [31:0] i_pc, input logic [31:0] i_alu,
                        input logic [31:0] i_rs2, input logic [2:0] i_f3,
                        input logic [4:0] i_rd, input logic i_rwe, input logic i_mr,
                        input logic i_mw, input logic [1:0] i_ws, input int gd,
                        input int rvd, input logic [31:0] i_rdata);
    int          sz;
    int          a;
    logic        is_mem, mis;
    logic [31:0] e_be, e_wd, e_ld, e_data, sh;
    is_mem = i_mr | i_mw;
    a = int'(i_alu[1:0]);
    if (i_mw) sz = (i_f3 == 3'd0) ? 1 : (i_f3 == 3'd1) ? 2 : 4;
    else      sz = (i_f3 == 3'd0 || i_f3 == 3'd4) ? 1 : (i_f3 == 3'd1 || i_f3 == 3'd5) ? 2 : 4;
    mis = is_mem && ((a % sz) != 0);
    sh = i_rdata >> (8 * a);
    if (sz == 1) begin
      e_be = 32'd1 << a;
      e_wd = (i_rs2 & 32'hFF) * 32'h01010101;
      e_ld = sh & 32'hFF;
      if (!i_f3[2] && e_ld >= 32'h80) e_ld = e_ld + 32'hFFFFFF00;
    end else if (sz == 2) begin
      e_be = 32'd3 << a;
      e_wd = (i_rs2 & 32'hFFFF) * 32'h00010001;
      e_ld = sh & 32'hFFFF;
      if (!i_f3[2] && e_ld >= 32'h8000) e_ld = e_ld + 32'hFFFF0000;
    end else begin
      e_be = 32'hF;
      e_wd = i_rs2;
      e_ld = i_rdata;
    end

    @(negedge clk);
    chk("ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; pc = i_pc; alu_res = i_alu; rs2data = i_rs2; funct3 = i_f3;
    rd = i_rd; regwren = i_rwe; memren = i_mr; memwren = i_mw; wbsel = i_ws;
    @(negedge clk);
    in_valid = 1'b0;
    alu_res = $urandom; rs2data = $urandom; funct3 = 3'($urandom);

    if (is_mem && !mis) begin
      for (int i = 0; i <= gd; i++) begin
        chk("req", {31'd0, dmem_req}, 32'd1);
        chk("we", {31'd0, dmem_we}, {31'd0, i_mw});
        chk("addr", dmem_addr, i_alu & 32'hFFFFFFFC);
        chk("be", {28'd0, dmem_be}, e_be);
        chk("wdata", dmem_wdata, e_wd);
        chk("ready_busy", {31'd0, in_ready}, 32'd0);
        // stray rvalid while requesting must be ignored
        dmem_rvalid = (i < gd) ? 1'($urandom) : 1'b0;
        dmem_rdata  = $urandom;
        dmem_gnt    = (i == gd);
        @(negedge clk);
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (!i_mw) begin
        for (int i = 0; i < rvd; i++) begin
          chk("req_wait", {31'd0, dmem_req}, 32'd0);
          chk("wbv_wait", {31'd0, wb_valid}, 32'd0);
          dmem_gnt = 1'($urandom);
          @(negedge clk);
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = i_rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        last_ld = e_ld;
      end
    end

    case (i_ws)
      2'd1:    e_data = last_ld;
      2'd2:    e_data = i_pc + 32'd4;
      default: e_data = i_alu;
    endcase
    chk("wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("wb_data", wb_data, e_data);
    chk("wb_regwren", {31'd0, wb_regwren}, {31'd0, i_rwe && i_rd != 5'd0 && !mis});
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, i_rd});
    chk("wb_pc", wb_pc, i_pc);
    chk("misalign", {31'd0, misalign}, {31'd0, mis});
    chk("req_wb", {31'd0, dmem_req}, 32'd0);
    chk("ready_wb", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("wb_pulse", {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pc = '0; alu_res = '0; rs2data = '0; funct3 = '0;
    rd = '0; regwren = 1'b0; memren = 1'b0; memwren = 1'b0; wbsel = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    rst = 1'b0;

    // ADD
    run_op(32'h40, 32'h1234, 32'h0, 3'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 32'h0);
    // SB to 0x103, gnt after 2 cycles
    run_op(32'h44, 32'h103, 32'hAB, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2, 0, 32'h0);
    // LB / LBU at 0x102
    run_op(32'h48, 32'h102, 32'h0, 3'd0, 5'd7, 1'b1, 1'b1, 1'b0, 2'd1, 0, 3, 32'h00800000);
    chk("lb_val", last_ld, 32'hFFFFFF80);
    run_op(32'h4C, 32'h102, 32'h0, 3'd4, 5'd7, 1'b1, 1'b1, 1'b0, 2'd1, 0, 3, 32'h00800000);
    chk("lbu_val", last_ld, 32'h00000080);
    // misaligned LW
    run_op(32'h50, 32'h202, 32'h0, 3'd2, 5'd8, 1'b1, 1'b1, 1'b0, 2'd1, 0, 0, 32'h0);
    // JAL at top of address space
    run_op(32'hFFFFFFFC, 32'h0, 32'h0, 3'd0, 5'd1, 1'b1, 1'b0, 1'b0, 2'd2, 0, 0, 32'h0);
    // SH / LH upper half, load+store both set
    run_op(32'h54, 32'h312, 32'hBEEF, 3'd1, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1, 0, 32'h0);
    run_op(32'h58, 32'h312, 32'h0, 3'd1, 5'd9, 1'b1, 1'b1, 1'b0, 2'd1, 1, 0, 32'h9ABC1234);
    run_op(32'h5C, 32'h400, 32'h11223344, 3'd2, 5'd3, 1'b1, 1'b1, 1'b1, 2'd0, 0, 0, 32'h0);

    // reset while waiting for rvalid; the late response is dropped
    @(negedge clk);
    in_valid = 1'b1; alu_res = 32'h300; funct3 = 3'd2; memren = 1'b1; memwren = 1'b0;
    wbsel = 2'd1; rd = 5'd4; regwren = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("wait_req", {31'd0, dmem_req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; last_ld = 32'h0;
    chk("rstw_req", {31'd0, dmem_req}, 32'd0);
    chk("rstw_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rstw_ready", {31'd0, in_ready}, 32'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("rstw_wbv2", {31'd0, wb_valid}, 32'd0);
    chk("rstw_ready2", {31'd0, in_ready}, 32'd1);

    // reset while requesting
    in_valid = 1'b1; alu_res = 32'h500; memren = 1'b0; memwren = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; memwren = 1'b0;
    chk("rstr_req1", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstr_req0", {31'd0, dmem_req}, 32'd0);
    chk("rstr_ready", {31'd0, in_ready}, 32'd1);

    // random ops
    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic        mr, mw;
      logic [1:0]  ws;
      kind = int'($urandom_range(0, 3));
      mr = (kind == 1 || kind == 3);
      mw = (kind == 2 || kind == 3);
      ws = 2'($urandom_range(0, 2));
      run_op($urandom, $urandom, $urandom, 3'($urandom), 5'($urandom), 1'($urandom),
             mr, mw, ws, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
